// File: rtl/mux_lanes_pkg.sv
// Shared constants for the two-lane merge block: default widths, lane ids, derived pointer/count widths.
package mux_lanes_pkg;
    localparam int DATA_WIDTH = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/mux2_1_lanes_arb_lane_fifo.sv
// Per-lane FIFO: head visible combinationally, pop applies at the clock edge.
// Latency: a word pushed at edge N is at the head after edge N.
// Backpressure: full blocks pushes; a push into a full FIFO is dropped and flagged, even with a same-cycle pop.
module lane_fifo
    import mux_lanes_pkg::*;
#(
    parameter int DATA_WIDTH = mux_lanes_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = mux_lanes_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign overflow = push && full;
    assign head     = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: rtl/mux2_1_lanes_arb.sv
// Two-lane merge: per-lane FIFOs, round-robin arbiter, registered valid/ready output tagged with source lane.
// Latency: push at edge N into an empty block shows valid_out after edge N+1; one word per cycle sustained.
// Backpressure: valid_out && !ready_out freezes the output stage; lanes fill to full. MUX_LANE_PARITY_EN adds parity_out.
module mux2_1_lanes_arb
    import mux_lanes_pkg::*;
#(
    parameter int DATA_WIDTH = mux_lanes_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = mux_lanes_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push0,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  push1,
    input  logic [DATA_WIDTH-1:0] data_in1,
    output logic                  full0,
    output logic                  full1,
    input  logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  select_out,
`ifdef MUX_LANE_PARITY_EN
    output logic                  overflow_err,
    output logic                  parity_out
`else
    output logic                  overflow_err
`endif
);
    logic [DATA_WIDTH-1:0] head0, head1, head_sel;
    logic                  empty0, empty1, ovf0, ovf1;
    logic                  pop0, pop1;
    logic                  grant, any_vld, advance, load;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;

    lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lane0 (
        .clk(clk), .reset_L(reset_L), .push(push0), .pop(pop0), .data_in(data_in0),
        .head(head0), .empty(empty0), .full(full0), .overflow(ovf0)
    );

    lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lane1 (
        .clk(clk), .reset_L(reset_L), .push(push1), .pop(pop1), .data_in(data_in1),
        .head(head1), .empty(empty1), .full(full1), .overflow(ovf1)
    );

    // Strict alternation only when both lanes compete; a lone lane always wins.
    always_comb begin
        if (!empty0 && !empty1)
            grant = ~last_q;
        else
            grant = empty0 ? LANE1 : LANE0;
    end

    assign any_vld  = !empty0 || !empty1;
    assign advance  = !valid_q || ready_out;
    assign load     = advance && any_vld;
    assign pop0     = load && (grant == LANE0);
    assign pop1     = load && (grant == LANE1);
    assign head_sel = (grant == LANE1) ? head1 : head0;

    always_comb begin
        valid_d = advance ? any_vld : valid_q;
        data_d  = load ? head_sel : data_q;
        sel_d   = load ? grant : sel_q;
        last_d  = load ? grant : last_q;
        ovf_d   = ovf_q | ovf0 | ovf1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= LANE0;
            last_q  <= LANE1;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MUX_LANE_PARITY_EN
    logic par_q, par_d;

    assign par_d = load ? ^{grant, head_sel} : par_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end

    assign parity_out = par_q;
`endif

    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign select_out   = sel_q;
    assign overflow_err = ovf_q;
endmodule
